vga_scan_timing_gen: RTL and testbench

Scan-timing source for the oscilloscope display: generates the 1280x1024@60 Hz raster coordinates `VGA_horzCoord`/`VGA_vertCoord` consumed by the label and overlay condition blocks. It samples their combined pixel CONDITION back and drives sync and colour to the VGA pins. Sync and colour are pipeline-aligned so the overlay logic between the two can be purely combinational.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_scan_timing_gen_if.sv | 42 ++++
 rtl/vga_scan_counter.sv | 43 ++++
 rtl/vga_scan_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_scan_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 1280x1024@60 Hz scan-timing generator.
//   - Horizontal/vertical active, porch, sync and total lengths
//   - Coordinate width (12 bits) and coordinate type
//   - 12-bit {R,G,B} colour type and the foreground/background colours
//   - Stage-1 pipeline record used by the top level
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W = 12;

  // Horizontal timing, in pixels.
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 248;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1688

  // Vertical timing, in lines.
  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 38;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 1066

  // Active level of both sync outputs.
  localparam logic SYNC_POL = 1'b1;

  typedef logic [COORD_W-1:0] coord_t;

  // {R[3:0], G[3:0], B[3:0]}
  typedef logic [11:0] colour_t;

  localparam colour_t FG_COLOUR = 12'hFFF;
  localparam colour_t BG_COLOUR = 12'h000;

  // Everything the output stage needs to know about one pixel position.
  typedef struct packed {
    logic cond;
    logic active;
    logic hs_raw;
    logic vs_raw;
    logic frame_start;
  } stage1_t;

  // Truncating conversion used to build coordinate-width compare constants.
  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_scan_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_scan_timing_gen_if
// Bundle between the scan-timing generator, the overlay condition logic and
// the VGA pins.
//   VGA_horzCoord / VGA_vertCoord : raster coordinates driven by the generator
//   CONDITION                     : combinational overlay result for those
//                                   coordinates, returned to the generator
//   VGA_HS / VGA_VS               : sync outputs
//   VGA_RED / VGA_GREEN / VGA_BLUE: 4-bit colour outputs
//   FRAME_START                   : one-cycle pulse for pixel (0,0)
// Modports: master = generator side, slave = overlay/pin side.
// -----------------------------------------------------------------------------
interface vga_scan_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t     VGA_horzCoord;
  coord_t     VGA_vertCoord;
  logic       CONDITION;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [3:0] VGA_RED;
  logic [3:0] VGA_GREEN;
  logic [3:0] VGA_BLUE;
  logic       FRAME_START;

  modport master (
    output VGA_horzCoord, VGA_vertCoord,
    output VGA_HS, VGA_VS,
    output VGA_RED, VGA_GREEN, VGA_BLUE,
    output FRAME_START,
    input  CONDITION
  );

  modport slave (
    input  VGA_horzCoord, VGA_vertCoord,
    input  VGA_HS, VGA_VS,
    input  VGA_RED, VGA_GREEN, VGA_BLUE,
    input  FRAME_START,
    output CONDITION
  );

endinterface

// File: rtl/vga_scan_counter.sv
// -----------------------------------------------------------------------------
// vga_scan_counter
// Free-running raster counters. h counts every clock; at its terminal value it
// wraps to 0 and v advances, with v wrapping to 0 when it is also terminal.
//   clk, rst : pixel clock, asynchronous active-high reset
//   h, v     : current column / line, straight from the registers
// -----------------------------------------------------------------------------
module vga_scan_counter
  import vga_timing_pkg::*;
#(
  parameter int LINE_LEN  = H_TOTAL,
  parameter int FRAME_LEN = V_TOTAL
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t h,
  output coord_t v
);

  localparam coord_t H_LAST = to_coord(LINE_LEN - 1);
  localparam coord_t V_LAST = to_coord(FRAME_LEN - 1);

  logic h_last;
  logic v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // NOTE: asynchronous reset in the sensitivity list, and non-blocking (<=)
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + coord_t'(1);
    end else begin
      h <= h + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_scan_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_timing_gen
// Scan-timing source for the oscilloscope display. Drives raster coordinates
// to the overlay logic, samples its combinational CONDITION and produces sync,
// colour and FRAME_START through a two-stage pipeline, so every pin lags its
// coordinate by exactly two clocks.
//   CLK_VGA : 108 MHz pixel clock
//   RESET   : asynchronous, active-high
//   vga     : vga_scan_timing_gen_if.master (coordinates, CONDITION, pins)
// Optional build macro VGA_BORDER_EN: paints the outermost active rows and
// columns in FG_COLOUR as a panel alignment aid.
// The timing parameters default to the 1280x1024 package constants.
// -----------------------------------------------------------------------------
module vga_scan_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT_PX  = H_ACTIVE,
  parameter int H_FP_PX   = H_FP,
  parameter int H_SYNC_PX = H_SYNC,
  parameter int H_BP_PX   = H_BP,
  parameter int V_ACT_LN  = V_ACTIVE,
  parameter int V_FP_LN   = V_FP,
  parameter int V_SYNC_LN = V_SYNC,
  parameter int V_BP_LN   = V_BP
) (
  input  logic                  CLK_VGA,
  input  logic                  RESET,
  vga_scan_timing_gen_if.master vga
);

  localparam int LINE_LEN  = H_ACT_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;
  localparam int FRAME_LEN = V_ACT_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

  localparam coord_t H_ACT_END = to_coord(H_ACT_PX);
  localparam coord_t HS_START  = to_coord(H_ACT_PX + H_FP_PX);
  localparam coord_t HS_END    = to_coord(H_ACT_PX + H_FP_PX + H_SYNC_PX);
  localparam coord_t V_ACT_END = to_coord(V_ACT_LN);
  localparam coord_t VS_START  = to_coord(V_ACT_LN + V_FP_LN);
  localparam coord_t VS_END    = to_coord(V_ACT_LN + V_FP_LN + V_SYNC_LN);

  coord_t h;
  coord_t v;

  vga_scan_counter #(
    .LINE_LEN  (LINE_LEN),
    .FRAME_LEN (FRAME_LEN)
  ) u_counter (
    .clk (CLK_VGA),
    .rst (RESET),
    .h   (h),
    .v   (v)
  );

  // Coordinates come straight from the counter flops, never from logic.
  assign vga.VGA_horzCoord = h;
  assign vga.VGA_vertCoord = v;

  // ---------------------------------------------------------------------------
  // Stage 1: decode the current position and capture CONDITION with it.
  // ---------------------------------------------------------------------------
  stage1_t s1_d;
  stage1_t s1_q;

  // NOTE: assign the whole record first so no path leaves a field unassigned
  // (which would infer a latch).
  always_comb begin
    s1_d             = '0;
    s1_d.cond        = vga.CONDITION;
    s1_d.active      = (h < H_ACT_END) && (v < V_ACT_END);
    s1_d.hs_raw      = (h >= HS_START) && (h < HS_END);
    s1_d.vs_raw      = (v >= VS_START) && (v < VS_END);
    s1_d.frame_start = (h == '0) && (v == '0);
  end

  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

`ifdef VGA_BORDER_EN
  localparam coord_t H_ACT_LAST = to_coord(H_ACT_PX - 1);
  localparam coord_t V_ACT_LAST = to_coord(V_ACT_LN - 1);

  logic border_d;
  logic border_q;

  assign border_d = s1_d.active &&
                    ((h == '0) || (h == H_ACT_LAST) ||
                     (v == '0) || (v == V_ACT_LAST));

  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      border_q <= 1'b0;
    end else begin
      border_q <= border_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: output registers feeding the pins.
  // ---------------------------------------------------------------------------
  colour_t colour_d;
  colour_t colour_q;
  logic    hs_q;
  logic    vs_q;
  logic    fs_q;

  // Blanking wins over everything, so CONDITION cannot light the porches.
  always_comb begin
    colour_d = '0;
    if (s1_q.active) begin
      colour_d = s1_q.cond ? FG_COLOUR : BG_COLOUR;
`ifdef VGA_BORDER_EN
      if (border_q) begin
        colour_d = FG_COLOUR;
      end
`endif
    end
  end

  // Sync flops hold the pin level, so reset lands on the inactive level.
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      fs_q     <= 1'b0;
      colour_q <= '0;
    end else begin
      hs_q     <= s1_q.hs_raw ? SYNC_POL : ~SYNC_POL;
      vs_q     <= s1_q.vs_raw ? SYNC_POL : ~SYNC_POL;
      fs_q     <= s1_q.frame_start;
      colour_q <= colour_d;
    end
  end

  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.FRAME_START = fs_q;
  assign vga.VGA_RED     = colour_q[11:8];
  assign vga.VGA_GREEN   = colour_q[7:4];
  assign vga.VGA_BLUE    = colour_q[3:0];

endmodule

// File: tb/tb_vga_scan_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_timing_gen
// Two instances share clock and reset: one with the real 1280x1024 timing
// (horizontal behaviour, reset, first frame pulse) and one with a tiny raster
// (8+2+3+3 pixels, 6+1+2+2 lines) so frame wrap, vertical sync and the frame
// pulse period are reached within a short run. A driver process tracks the
// expected raster position, checks the coordinates, and queues the expected
// pin values two cycles ahead; a monitor on the falling edge pops and
// compares them.
// -----------------------------------------------------------------------------
module tb_vga_scan_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
  } pins_t;

  typedef struct {
    int    due;
    pins_t pins;
  } exp_t;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int tgt;  // column that CONDITION selects in mode 0
  } geom_t;

  localparam geom_t G_FULL  = '{ha: 1280, hfp: 48, hsw: 112, hbp: 248,
                                va: 1024, vfp: 1,  vsw: 3,   vbp: 38, tgt: 245};
  localparam geom_t G_SMALL = '{ha: 8, hfp: 2, hsw: 3, hbp: 3,
                                va: 6, vfp: 1, vsw: 2, vbp: 2, tgt: 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;      // 0: CONDITION = (h == tgt), 1: tied high, 2: tied low
  int   c = 0;         // cycles since the last reset release
  int   epoch = 0;
  bit   checking = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q_full[$];
  exp_t q_small[$];

  // Directed statistics gathered by the monitor during the first run.
  int hs_cnt = 0;
  int first_hs = -1;
  int last_hs = -1;
  int full_fs_cnt = 0;
  int small_fs_cnt = 0;
  int small_fs_bad = 0;
  int small_vs_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic cond_of(input int m, input int h, input int tgt);
    return (m == 1) || ((m == 0) && (h == tgt));
  endfunction

  vga_scan_timing_gen_if if_full ();
  vga_scan_timing_gen_if if_small ();

  assign if_full.CONDITION  = cond_of(mode, int'(if_full.VGA_horzCoord), G_FULL.tgt);
  assign if_small.CONDITION = cond_of(mode, int'(if_small.VGA_horzCoord), G_SMALL.tgt);

  vga_scan_timing_gen dut_full (
    .CLK_VGA (clk),
    .RESET   (rst),
    .vga     (if_full)
  );

  vga_scan_timing_gen #(
    .H_ACT_PX  (8),
    .H_FP_PX   (2),
    .H_SYNC_PX (3),
    .H_BP_PX   (3),
    .V_ACT_LN  (6),
    .V_FP_LN   (1),
    .V_SYNC_LN (2),
    .V_BP_LN   (2)
  ) dut_small (
    .CLK_VGA (clk),
    .RESET   (rst),
    .vga     (if_small)
  );

  pins_t pins_full;
  pins_t pins_small;
  assign pins_full  = {if_full.VGA_HS, if_full.VGA_VS, if_full.FRAME_START,
                       if_full.VGA_RED, if_full.VGA_GREEN, if_full.VGA_BLUE};
  assign pins_small = {if_small.VGA_HS, if_small.VGA_VS, if_small.FRAME_START,
                       if_small.VGA_RED, if_small.VGA_GREEN, if_small.VGA_BLUE};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int line_len(input geom_t g);
    return g.ha + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int frame_len(input geom_t g);
    return g.va + g.vfp + g.vsw + g.vbp;
  endfunction

  function automatic int h_at(input geom_t g, input int cyc);
    return cyc % line_len(g);
  endfunction

  function automatic int v_at(input geom_t g, input int cyc);
    return (cyc / line_len(g)) % frame_len(g);
  endfunction

  // Sync is active-high, so the idle level of every pin is 0.
  function automatic pins_t reset_pins();
    pins_t p;
    p = '0;
    return p;
  endfunction

  function automatic pins_t model(input geom_t g, input int cyc, input int m);
    pins_t p;
    int    h;
    int    v;
    logic  act;
    h     = h_at(g, cyc);
    v     = v_at(g, cyc);
    act   = (h < g.ha) && (v < g.va);
    p.hs  = (h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsw);
    p.vs  = (v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsw);
    p.fs  = (h == 0) && (v == 0);
    p.rgb = (act && cond_of(m, h, g.tgt)) ? 12'hFFF : 12'h000;
`ifdef VGA_BORDER_EN
    if (act && ((h == 0) || (h == g.ha - 1) || (v == 0) || (v == g.va - 1))) begin
      p.rgb = 12'hFFF;
    end
`endif
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_coords();
    check($sformatf("coord_full c=%0d", c),
          32'({if_full.VGA_vertCoord, if_full.VGA_horzCoord}),
          32'((v_at(G_FULL, c) << 12) | h_at(G_FULL, c)));
    check($sformatf("coord_small c=%0d", c),
          32'({if_small.VGA_vertCoord, if_small.VGA_horzCoord}),
          32'((v_at(G_SMALL, c) << 12) | h_at(G_SMALL, c)));
  endtask

  task automatic check_reset_state(input string tag);
    check({"reset_pins_full ", tag}, 32'(pins_full), 32'(reset_pins()));
    check({"reset_pins_small ", tag}, 32'(pins_small), 32'(reset_pins()));
    check({"reset_coord_full ", tag},
          32'({if_full.VGA_vertCoord, if_full.VGA_horzCoord}), 32'(0));
    check({"reset_coord_small ", tag},
          32'({if_small.VGA_vertCoord, if_small.VGA_horzCoord}), 32'(0));
  endtask

  // Coordinates seen during cycle cyc reach the pins during cycle cyc+2.
  task automatic push_expected(input int cyc, input int m);
    exp_t e;
    e.due  = cyc + 2;
    e.pins = model(G_FULL, cyc, m);
    q_full.push_back(e);
    e.pins = model(G_SMALL, cyc, m);
    q_small.push_back(e);
  endtask

  // Releases reset just after a rising edge; the next edge is the first one
  // that samples the counters at (0,0).
  task automatic release_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    c   = 0;
    q_full.delete();
    q_small.delete();
    e.pins = reset_pins();
    for (int d = 0; d < 2; d++) begin
      e.due = d;
      q_full.push_back(e);
      q_small.push_back(e);
    end
    check_coords();
    push_expected(0, mode);
    checking = 1'b1;
  endtask

  task automatic run(input int n, input int m);
    repeat (n) begin
      @(posedge clk);
      #1;
      c++;
      mode = m;
      check_coords();
      push_expected(c, m);
    end
  endtask

  // Assert reset mid-run; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    checking = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("held");
    epoch = 1;
    release_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      if (q_full.size() == 0) begin
        check($sformatf("queue_full_empty c=%0d", c), 32'(0), 32'(1));
      end else begin
        e = q_full.pop_front();
        check($sformatf("pins_full c=%0d", c), 32'(pins_full), 32'(e.pins));
      end
      if (q_small.size() == 0) begin
        check($sformatf("queue_small_empty c=%0d", c), 32'(0), 32'(1));
      end else begin
        e = q_small.pop_front();
        check($sformatf("pins_small c=%0d", c), 32'(pins_small), 32'(e.pins));
      end

      if (epoch == 0) begin
        if (c >= 2 && c < 2 + 1688 && if_full.VGA_HS) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = c;
          last_hs = c;
        end
        if (if_full.FRAME_START) full_fs_cnt++;
        if (c >= 2 && c < 2 + 3 * 176) begin
          if (if_small.FRAME_START) begin
            small_fs_cnt++;
            if ((c - 2) % 176 != 0) small_fs_bad++;
          end
          if (if_small.VGA_VS) small_vs_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst  = 1'b1;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("initial");

    release_reset();
    run(2 * 1688 + 200, 0);  // two full lines plus part of a third, column 245 lit
    run(1688, 1);            // CONDITION high: blanking must still show black
    run(500, 1);             // full-size raster now at h=700, v=3
    pulse_reset();
    run(400, 2);             // CONDITION low after restart from (0,0)
    checking = 1'b0;

    check("hs_pulse_cycles_line0", 32'(hs_cnt), 32'(112));
    check("hs_first_output_cycle", 32'(first_hs), 32'(1330));
    check("hs_last_output_cycle", 32'(last_hs), 32'(1441));
    check("full_frame_start_count", 32'(full_fs_cnt), 32'(1));
    check("small_frame_start_count", 32'(small_fs_cnt), 32'(3));
    check("small_frame_start_period", 32'(small_fs_bad), 32'(0));
    check("small_vs_cycles_3_frames", 32'(small_vs_cnt), 32'(96));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
